fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the single-cycle MIPS core. Owns the PC register and drives the word-indexed instruction memory through a req/ack handshake.
- Presents each fetched word to the decode/execute stage through a valid/ready interface.
- Applies branch/jump redirects, detects the program EXIT address, and traps out-of-range or hung fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset and on every start.
- HALT_PC, 32'h0000_007C, EXIT address (word 31); reaching it halts cleanly.
- DEPTH, 30, number of valid instruction words; a legal fetch address is below DEPTH*4.
- TIMEOUT, 16, maximum FETCH cycles without im_ack before a trap (≥1).

Ports:
- clk in 1: single clock, rising edge.
- rst_n in 1: synchronous, active-low reset.
- start in 1: begin or restart execution from RESET_PC.
- im_req out 1: fetch request to instruction memory.
- im_pc out 32: byte address to instruction memory; the memory indexes by im_pc/4.
- im_ack in 1: im_data is valid this cycle.
- im_data in 32: instruction word.
- inst out 32: held instruction.
- inst_pc out 32: address of inst.
- inst_valid out 1: inst/inst_pc are valid.
- inst_ready in 1: consumer accepts inst this cycle.
- redirect in 1: qualifies redirect_pc. Sampled only on an accept cycle (inst_valid && inst_ready).
- redirect_pc in 32: taken branch/jump target.
- halted out 1: EXIT reached or trap.
- err out 1: trap cause present (out-of-range address or timeout).
- retired out 16: count of accepted instructions.

Behaviour:
- Reset (rst_n=0 at a clk edge, from any state, including mid-fetch): state=IDLE; pc=RESET_PC; im_req=0; im_pc=RESET_PC; inst=0; inst_pc=0; inst_valid=0; halted=0; err=0; retired=0; timeout counter=0.
- States: IDLE, FETCH, HOLD, HALT. im_pc always equals pc.
- IDLE:
  - im_req=0.
  - start=1 → FETCH. pc=RESET_PC, retired=0, err=0, halted=0.
- FETCH:
  - im_req=1. im_pc is held stable until ack.
  - im_ack=1 → inst<=im_data, inst_pc<=pc, inst_valid<=1, go to HOLD. im_req falls on the same edge.
  - Minimum fetch latency is 1 cycle: im_req is high in cycle N, im_ack arrives in cycle N, and inst_valid is high in cycle N+1.
  - Each cycle without ack increments the timeout counter. When the counter reaches TIMEOUT-1 with no ack → HALT with err=1.
- HOLD:
  - inst_valid=1. inst and inst_pc are held stable while inst_ready=0, with no limit on stall length.
  - On accept: retired increments, saturating at 16'hFFFF. inst_valid<=0. Compute next.
  - next = redirect ? {redirect_pc[31:2],2'b00} : inst_pc+4. The addition is 32-bit and wraps modulo 2^32.
  - next==HALT_PC → HALT with err=0.
  - Otherwise, next ≥ DEPTH*4 → HALT with err=1.
  - Otherwise pc<=next and go to FETCH. The next im_req is asserted the cycle after accept; there are no bubbles beyond that.
- HALT:
  - halted=1, im_req=0, inst_valid=0. pc retains the offending or EXIT address for debug.
  - start=1 → same action as start in IDLE.
- start is ignored in FETCH and HOLD.
- im_ack is ignored outside FETCH.
- redirect is ignored except on accept cycles.
- Simultaneous redirect and accept: redirect wins over sequential PC+4.
- inst_ready may be asserted without inst_valid; this has no effect.

Test Plan:
1. Sequential fetch: reset, start, im_ack returned 1 cycle after each req, inst_ready=1 held. Required: im_pc sequence 0x00,0x04,0x08…; inst_valid pulses with matching inst_pc; retired=3 after three accepts.
2. Redirect: accept at inst_pc=0x44 with redirect=1, redirect_pc=0x0000_0039. Required: next im_pc=0x38, not 0x48; accepting inst_pc=0x38 with redirect=0 gives im_pc=0x3C.
3. Clean halt: accept with redirect_pc=0x7C. Required: next cycle halted=1, err=0, im_req=0; a later start returns im_pc=0x00, retired=0, halted=0.
4. Out-of-range: sequential accept at inst_pc=0x74. Required: next=0x78 ≥ 120 and ≠ HALT_PC, so halted=1, err=1.
5. Backpressure and timeout: inst_ready=0 for 10 cycles. Required: inst/inst_pc stable and no new im_req. Then withhold im_ack in FETCH. Required: halted=1, err=1 exactly TIMEOUT cycles after im_req rose.
6. Reset mid-operation: rst_n=0 for one edge while in FETCH and again while in HOLD. Required: all outputs at reset values next cycle; state IDLE; no im_req until start.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches words over a req/ack handshake,
// and holds each word on a valid/ready interface until the consumer accepts it.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] HALT_PC  = 32'h0000_007C,
  parameter int unsigned DEPTH    = 30,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        im_req,
  output logic [31:0] im_pc,
  input  logic        im_ack,
  input  logic [31:0] im_data,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic        err,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_HALT
  } state_e;

  localparam logic [31:0] PC_LIMIT = 32'(DEPTH * 4);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        err_q, err_d;
  logic [15:0] retired_q, retired_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] next_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      err_q     <= err_d;
      retired_q <= retired_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    err_d     = err_q;
    retired_d = retired_q;
    tmo_d     = tmo_q;
    next_pc   = redirect ? (redirect_pc & ~32'h0000_0003) : (inst_pc_q + 32'd4);

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = RESET_PC;
          retired_d = '0;
          err_d     = 1'b0;
          tmo_d     = '0;
        end
      end
      S_FETCH: begin
        if (im_ack) begin
          inst_d    = im_data;
          inst_pc_d = pc_q;
          state_d   = S_HOLD;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          if (retired_q != '1) retired_d = retired_q + 16'd1;
          // pc takes the target even when halting so the EXIT/offending address stays visible
          pc_d = next_pc;
          if (next_pc == HALT_PC) begin
            state_d = S_HALT;
            err_d   = 1'b0;
          end else if (next_pc >= PC_LIMIT) begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end else begin
            state_d = S_FETCH;
            tmo_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign im_req     = (state_q == S_FETCH);
  assign im_pc      = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = (state_q == S_HOLD);
  assign halted     = (state_q == S_HALT);
  assign err        = err_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a transaction-level model is compared every cycle,
// and hand-computed expectations pin key points of each scenario.
module tb_fetch_ctrl;

  localparam int unsigned TIMEOUT = 16;
  localparam logic [31:0] HALT_PC = 32'h0000_007C;
  localparam logic [31:0] LIMIT   = 32'd120;

  logic        clk = 1'b0;
  logic        rst_n, start, im_req, im_ack, inst_valid, inst_ready, redirect, halted, err;
  logic [31:0] im_pc, im_data, inst, inst_pc, redirect_pc;
  logic [15:0] retired;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .RESET_PC(32'h0000_0000),
    .HALT_PC (HALT_PC),
    .DEPTH   (30),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .im_req     (im_req),
    .im_pc      (im_pc),
    .im_ack     (im_ack),
    .im_data    (im_data),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halted     (halted),
    .err        (err),
    .retired    (retired)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;
  logic auto_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: acks any pending request when enabled; data tags the address.
  task automatic tick();
    @(posedge clk);
    #1;
    im_ack  = auto_ack & im_req;
    im_data = 32'hC000_0000 | im_pc;
  endtask

  // Behavioural model: tracks the pending fetch, the held word and the halt cause.
  logic        m_req, m_valid, m_halted, m_err;
  logic [31:0] m_pc, m_inst, m_inst_pc, m_nxt;
  int unsigned cyc = 0;
  int unsigned m_fs = 0;
  int unsigned m_acc = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_req = 0; m_valid = 0; m_halted = 0; m_err = 0;
      m_pc = 0; m_inst = 0; m_inst_pc = 0; m_acc = 0;
    end else if (m_req) begin
      if (im_ack) begin
        m_inst = im_data; m_inst_pc = m_pc; m_valid = 1; m_req = 0;
      end else if (cyc - m_fs == TIMEOUT - 1) begin
        m_req = 0; m_halted = 1; m_err = 1;
      end
    end else if (m_valid) begin
      if (inst_ready) begin
        m_acc++;
        m_valid = 0;
        m_nxt = redirect ? {redirect_pc[31:2], 2'b00} : m_inst_pc + 32'd4;
        m_pc = m_nxt;
        if (m_nxt == HALT_PC) begin
          m_halted = 1; m_err = 0;
        end else if (m_nxt >= LIMIT) begin
          m_halted = 1; m_err = 1;
        end else begin
          m_req = 1; m_fs = cyc + 1;
        end
      end
    end else if (start) begin
      m_pc = 0; m_acc = 0; m_err = 0; m_halted = 0; m_req = 1; m_fs = cyc + 1;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_im_req",     im_req,     m_req);
      chk("m_im_pc",      im_pc,      m_pc);
      chk("m_inst",       inst,       m_inst);
      chk("m_inst_pc",    inst_pc,    m_inst_pc);
      chk("m_inst_valid", inst_valid, m_valid);
      chk("m_halted",     halted,     m_halted);
      chk("m_err",        err,        m_err);
      chk("m_retired",    retired,    (m_acc > 65535) ? 16'hFFFF : 16'(m_acc));
    end
  end

  initial begin
    logic [31:0] hold_inst, hold_pc;
    bit found;
    rst_n = 0; start = 0; im_ack = 0; im_data = 0;
    inst_ready = 0; redirect = 0; redirect_pc = 0;
    tick(); tick();
    chk_en = 1;
    rst_n = 1;
    chk("rst_im_req", im_req, 0);
    chk("rst_im_pc", im_pc, 32'h0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 16'd0);
    tick(); tick();
    chk("idle_no_req", im_req, 0);

    // 1: sequential fetch
    auto_ack = 1; inst_ready = 1;
    start = 1; tick(); start = 0;
    chk("t1_req", im_req, 1);
    chk("t1_pc0", im_pc, 32'h0);
    tick();
    chk("t1_valid", inst_valid, 1);
    chk("t1_inst0", inst, 32'hC000_0000);
    tick();
    chk("t1_pc4", im_pc, 32'h4);
    tick(); tick(); tick(); tick();
    chk("t1_pcC", im_pc, 32'hC);
    chk("t1_retired3", retired, 16'd3);

    // 2: redirect with unaligned target
    found = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (inst_valid && inst_pc == 32'h44) begin
        found = 1;
        break;
      end
    end
    chk("t2_reach_44", found, 1);
    redirect = 1; redirect_pc = 32'h0000_0039;
    tick();
    redirect = 0;
    chk("t2_pc38", im_pc, 32'h38);
    tick(); tick();
    chk("t2_pc3C", im_pc, 32'h3C);

    // 3: clean halt at EXIT, then restart
    tick();
    redirect = 1; redirect_pc = HALT_PC;
    tick();
    redirect = 0;
    chk("t3_halted", halted, 1);
    chk("t3_err0", err, 0);
    chk("t3_noreq", im_req, 0);
    tick(); tick();
    start = 1; tick(); start = 0;
    chk("t3_restart_pc", im_pc, 32'h0);
    chk("t3_restart_ret", retired, 16'd0);
    chk("t3_restart_halt", halted, 0);

    // 4: out-of-range sequential successor of 0x74
    tick();
    redirect = 1; redirect_pc = 32'h74;
    tick();
    redirect = 0;
    chk("t4_pc74", im_pc, 32'h74);
    tick(); tick();
    chk("t4_halted", halted, 1);
    chk("t4_err1", err, 1);

    // 5: backpressure (start/redirect ignored while held), then fetch timeout
    inst_ready = 0;
    start = 1; tick(); start = 0;
    tick();
    chk("t5_valid", inst_valid, 1);
    hold_inst = inst; hold_pc = inst_pc;
    for (int k = 0; k < 10; k++) begin
      start = 1; redirect = 1; redirect_pc = 32'h20;
      tick();
      chk("t5_inst_stable", inst, hold_inst);
      chk("t5_pc_stable", inst_pc, hold_pc);
      chk("t5_no_req", im_req, 0);
    end
    start = 0; redirect = 0;
    auto_ack = 0; inst_ready = 1;
    tick();
    chk("t5_fetch_pc4", im_pc, 32'h4);
    chk("t5_req_rose", im_req, 1);
    for (int k = 1; k <= int'(TIMEOUT); k++) begin
      tick();
      if (k < int'(TIMEOUT)) chk("t5_not_yet", halted, 0);
      else begin
        chk("t5_tmo_halt", halted, 1);
        chk("t5_tmo_err", err, 1);
      end
    end

    // 6: reset while fetching, then while holding
    start = 1; tick(); start = 0;
    tick();
    chk("t6_in_fetch", im_req, 1);
    rst_n = 0; tick(); rst_n = 1;
    chk("t6a_req", im_req, 0);
    chk("t6a_inst", inst, 32'h0);
    chk("t6a_err", err, 0);
    tick(); tick();
    chk("t6a_idle", im_req, 0);
    auto_ack = 1; inst_ready = 1;
    start = 1; tick(); start = 0;
    tick(); tick(); tick(); tick();
    inst_ready = 0;
    tick();
    chk("t6b_hold", inst_valid, 1);
    chk("t6b_ret2", retired, 16'd2);
    rst_n = 0; tick(); rst_n = 1;
    chk("t6b_valid", inst_valid, 0);
    chk("t6b_ret", retired, 16'd0);
    chk("t6b_pc", im_pc, 32'h0);
    tick(); tick();
    chk("t6b_idle", im_req, 0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
